// File: rtl/oddr_ser_ctrl_pkg.sv
// Shared definitions for the ODDR serializer controller: FSM encoding,
// pair-counter sizing and the underrun counter ceiling.
package oddr_ser_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

  // Width of a counter spanning 0..word_width/2-1, never narrower than one bit.
  function automatic int pair_cnt_width(input int word_width);
    return (word_width <= 2) ? 1 : $clog2(word_width / 2);
  endfunction

endpackage

// File: rtl/oddr_ser_shifter.sv
// W-bit pair shifter: the two top bits of the register drive ODDR D1/D2
// directly, so the pair outputs come straight from flops.
module oddr_ser_shifter
  import oddr_ser_ctrl_pkg::*;
#(
  parameter int         WORD_WIDTH   = 16,
  parameter bit         MSB_FIRST    = 1'b1,
  parameter logic [1:0] IDLE_PATTERN = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] load_data,
  output logic                  d1,
  output logic                  d2,
  output logic                  last
);

  localparam int CW = pair_cnt_width(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_PAIR = CW'(WORD_WIDTH / 2 - 1);
  localparam logic [WORD_WIDTH-1:0] IDLE_WORD = WORD_WIDTH'(IDLE_PATTERN) << (WORD_WIDTH - 2);

  logic [WORD_WIDTH-1:0] data_reg;
  logic [CW-1:0]         cnt_reg;
  logic [WORD_WIDTH-1:0] oriented;

  // LSB-first order is a plain bit reversal, after which both orders shift left.
  for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_orient
    assign oriented[gi] = MSB_FIRST ? load_data[gi] : load_data[WORD_WIDTH-1-gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= IDLE_WORD;
      cnt_reg  <= '0;
    end else if (load) begin
      data_reg <= oriented;
      cnt_reg  <= '0;
    end else if (advance) begin
      data_reg <= data_reg << 2;
      cnt_reg  <= cnt_reg + CW'(1);
    end else if (flush) begin
      data_reg <= IDLE_WORD;
      cnt_reg  <= '0;
    end
  end

  assign d1   = data_reg[WORD_WIDTH-1];
  assign d2   = data_reg[WORD_WIDTH-2];
  assign last = (cnt_reg == LAST_PAIR);

endmodule

// File: rtl/oddr_ser_ctrl.sv
// Streaming 2-bit-per-clock serializer controller for one ODDR cell:
// valid/ready intake, one-word holding register, CE control and underrun count.
module oddr_ser_ctrl
  import oddr_ser_ctrl_pkg::*;
#(
  parameter int         WORD_WIDTH   = 16,
  parameter bit         MSB_FIRST    = 1'b1,
  parameter logic [1:0] IDLE_PATTERN = 2'b00
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic [WORD_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  output logic                  ODDR_D1,
  output logic                  ODDR_D2,
  output logic                  ODDR_CE,
  output logic                  FRAME,
  output logic                  BUSY,
  output logic [7:0]            UNDERRUN_CNT
);

  if ((WORD_WIDTH % 2) != 0 || WORD_WIDTH < 2 || WORD_WIDTH > 64) begin : g_bad_width
    $error("oddr_ser_ctrl: WORD_WIDTH must be even and within 2..64");
  end

  ser_state_e            state_reg;
  logic [WORD_WIDTH-1:0] hold_reg;
  logic                  hold_full_reg;
  logic                  started_reg;
  logic                  ce_reg;
  logic                  frame_reg;
  logic                  busy_reg;
  logic [7:0]            underrun_reg;

  logic                  accept;
  logic                  last;
  logic                  load;
  logic                  load_from_hold;
  logic                  advance;
  logic                  flush;
  logic [WORD_WIDTH-1:0] load_data;

  assign DATA_READY = ENABLE & ~hold_full_reg & ~RST;
  assign accept     = DATA_VALID & DATA_READY;
  assign load_data  = load_from_hold ? hold_reg : DATA_IN;

  // Shifter control: a load at the last pair keeps consecutive words gapless.
  always_comb begin
    load           = 1'b0;
    load_from_hold = 1'b0;
    advance        = 1'b0;
    flush          = 1'b0;
    if (state_reg == ST_IDLE) begin
      load = accept;
    end else if (!last) begin
      advance = 1'b1;
    end else if (hold_full_reg) begin
      load           = 1'b1;
      load_from_hold = 1'b1;
    end else if (accept) begin
      load = 1'b1;
    end else begin
      flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      started_reg   <= 1'b0;
      ce_reg        <= 1'b0;
      frame_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      underrun_reg  <= '0;
    end else begin
      if (state_reg == ST_IDLE) begin
        if (load) state_reg <= ST_SHIFT;
      end else if (flush) begin
        state_reg <= ST_IDLE;
      end

      if (advance && accept) begin
        hold_reg      <= DATA_IN;
        hold_full_reg <= 1'b1;
      end else if (load_from_hold) begin
        hold_full_reg <= 1'b0;
      end

      // A full holding register implies the shifter is busy, so load|advance covers both.
      busy_reg  <= load | advance;
      frame_reg <= load;
      ce_reg    <= ENABLE | busy_reg;

      if (accept) begin
        started_reg <= 1'b1;
      end else if (!ENABLE) begin
        started_reg <= 1'b0;
      end

      if (ENABLE && state_reg == ST_IDLE && started_reg && underrun_reg != UNDERRUN_MAX) begin
        underrun_reg <= underrun_reg + 8'd1;
      end
    end
  end

  oddr_ser_shifter #(
    .WORD_WIDTH   (WORD_WIDTH),
    .MSB_FIRST    (MSB_FIRST),
    .IDLE_PATTERN (IDLE_PATTERN)
  ) u_shifter (
    .clk       (CLK),
    .rst       (RST),
    .load      (load),
    .advance   (advance),
    .flush     (flush),
    .load_data (load_data),
    .d1        (ODDR_D1),
    .d2        (ODDR_D2),
    .last      (last)
  );

  assign ODDR_CE      = ce_reg;
  assign FRAME        = frame_reg;
  assign BUSY         = busy_reg;
  assign UNDERRUN_CNT = underrun_reg;

endmodule
